// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues block requests at the predicted PC and
// presents each returned block, tagged with its PC and branch bounds, to the queue.
module fetch_controller #(
  parameter int BW_ADDRESS         = 32,
  parameter int BW_PROCESSOR_DATA  = 32,
  parameter int BW_PROCESSOR_BLOCK = 64,
  parameter int NUM_GLOBAL_HISTORY = 4,
  parameter logic [BW_ADDRESS-1:0] RESET_PC = '0,
  parameter int NUM_ENTRY = BW_PROCESSOR_BLOCK / BW_PROCESSOR_DATA,
  parameter int BW_PC_MOD = $clog2(NUM_ENTRY) + ((NUM_ENTRY <= 1) ? 1 : 0)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_redirect_valid,
  input  logic [BW_ADDRESS-1:0]         i_redirect_pc,
  output logic [BW_ADDRESS-1:0]         o_pc,
  input  logic [BW_ADDRESS-1:0]         i_predicted_pc,
  input  logic [BW_PC_MOD-1:0]          i_pc_upperbound,
  input  logic [NUM_GLOBAL_HISTORY-1:0] i_global_history,
  output logic                          o_imem_valid,
  input  logic                          i_imem_ready,
  output logic [BW_ADDRESS-1:0]         o_imem_addr,
  input  logic                          i_imem_rdata_valid,
  input  logic [BW_PROCESSOR_BLOCK-1:0] i_imem_rdata,
  output logic                          o_inst_valid,
  input  logic                          i_inst_ready,
  output logic [BW_PROCESSOR_BLOCK-1:0] o_inst_data,
  output logic [BW_ADDRESS-1:0]         o_inst_pc,
  output logic [BW_PC_MOD-1:0]          o_inst_lowerbound,
  output logic [BW_PC_MOD-1:0]          o_inst_upperbound,
  output logic [NUM_GLOBAL_HISTORY-1:0] o_inst_global_history
);

  localparam int LOW_BITS = BW_PC_MOD + 2;
  localparam logic [BW_ADDRESS-1:0] BLOCK_MASK = {{(BW_ADDRESS-LOW_BITS){1'b1}}, {LOW_BITS{1'b0}}};
  localparam logic [BW_ADDRESS-1:0] WORD_MASK  = {{(BW_ADDRESS-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                          state;
  state_t                          state_next;
  logic [BW_ADDRESS-1:0]           pc;
  logic [BW_ADDRESS-1:0]           pc_next;
  logic [BW_ADDRESS-1:0]           tag_pc;
  logic [BW_PC_MOD-1:0]            tag_ub;
  logic [NUM_GLOBAL_HISTORY-1:0]   tag_gh;
  logic                            accept;
  logic                            tag_load;
  logic                            inst_load;

  assign o_pc              = pc;
  assign o_imem_addr       = pc & BLOCK_MASK;
  assign o_imem_valid      = (state == S_REQ);
  assign o_inst_valid      = (state == S_HOLD);
  assign accept            = o_imem_valid && i_imem_ready;
  assign o_inst_lowerbound = o_inst_pc[BW_PC_MOD+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // A redirect always wins the PC; the state only decides whether a
  // response still in flight must be swallowed before fetching again.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    tag_load   = 1'b0;
    inst_load  = 1'b0;
    case (state)
      S_REQ: begin
        if (accept) begin
          tag_load   = 1'b1;
          pc_next    = i_predicted_pc;
          state_next = i_redirect_valid ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_imem_rdata_valid) begin
          inst_load  = !i_redirect_valid;
          state_next = i_redirect_valid ? S_REQ : S_HOLD;
        end else if (i_redirect_valid) begin
          state_next = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (i_redirect_valid || i_inst_ready) begin
          state_next = S_REQ;
        end
      end
      S_DRAIN: begin
        if (i_imem_rdata_valid) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
    if (i_redirect_valid) begin
      pc_next = i_redirect_pc & WORD_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pc <= '0;
      tag_ub <= '0;
      tag_gh <= '0;
    end else if (tag_load) begin
      tag_pc <= pc;
      tag_ub <= i_pc_upperbound;
      tag_gh <= i_global_history;
    end
  end

  // Output entry registers stay frozen for the whole hold so the queue sees stable data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_inst_data           <= '0;
      o_inst_pc             <= '0;
      o_inst_upperbound     <= '0;
      o_inst_global_history <= '0;
    end else if (inst_load) begin
      o_inst_data           <= i_imem_rdata;
      o_inst_pc             <= tag_pc;
      o_inst_upperbound     <= tag_ub;
      o_inst_global_history <= tag_gh;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed vector table, hand-written
// corner sequences, then random traffic against a transaction-level model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic [31:0] o_pc;
  logic [31:0] i_predicted_pc = '0;
  logic [0:0]  i_pc_upperbound = '0;
  logic [3:0]  i_global_history = '0;
  logic        o_imem_valid;
  logic        i_imem_ready = 1'b0;
  logic [31:0] o_imem_addr;
  logic        i_imem_rdata_valid = 1'b0;
  logic [63:0] i_imem_rdata = '0;
  logic        o_inst_valid;
  logic        i_inst_ready = 1'b0;
  logic [63:0] o_inst_data;
  logic [31:0] o_inst_pc;
  logic [0:0]  o_inst_lowerbound;
  logic [0:0]  o_inst_upperbound;
  logic [3:0]  o_inst_global_history;

  int tests = 0;
  int fails = 0;

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_pc(o_pc), .i_predicted_pc(i_predicted_pc),
    .i_pc_upperbound(i_pc_upperbound), .i_global_history(i_global_history),
    .o_imem_valid(o_imem_valid), .i_imem_ready(i_imem_ready), .o_imem_addr(o_imem_addr),
    .i_imem_rdata_valid(i_imem_rdata_valid), .i_imem_rdata(i_imem_rdata),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
    .o_inst_data(o_inst_data), .o_inst_pc(o_inst_pc),
    .o_inst_lowerbound(o_inst_lowerbound), .o_inst_upperbound(o_inst_upperbound),
    .o_inst_global_history(o_inst_global_history)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] pred;
    logic        ub;
    logic [3:0]  gh;
    logic        ready;
    logic        rv;
    logic [63:0] rdata;
    logic        iready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic        e_lb;
    logic        e_ub;
    logic [63:0] e_data;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [31:0] pc;
    logic        ub;
    logic [3:0]  gh;
  } entry_t;

  typedef struct {
    logic [63:0] data;
    int          due;
  } mreq_t;

  localparam logic [63:0] D1 = 64'h11112222_33334444;
  localparam logic [63:0] D2 = 64'hAAAA5555_0F0F1234;
  localparam logic [63:0] D3 = 64'hDEADBEEF_CAFEF00D;

  vec_t vecs[16];

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic [31:0] pred,
                              input logic ub, input logic [3:0] gh, input logic ready,
                              input logic rv, input logic [63:0] rdata, input logic iready,
                              input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_pc, input logic e_lb, input logic e_ub,
                              input logic [63:0] e_data);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.pred = pred; v.ub = ub; v.gh = gh;
    v.ready = ready; v.rv = rv; v.rdata = rdata; v.iready = iready;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
    v.e_lb = e_lb; v.e_ub = e_ub; v.e_data = e_data;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the negedge, then advance to the next negedge.
  task automatic applyStimulus(input vec_t v);
    i_redirect_valid   = v.redir;
    i_redirect_pc      = v.rpc;
    i_predicted_pc     = v.pred;
    i_pc_upperbound    = v.ub;
    i_global_history   = v.gh;
    i_imem_ready       = v.ready;
    i_imem_rdata_valid = v.rv;
    i_imem_rdata       = v.rdata;
    i_inst_ready       = v.iready;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    i_redirect_valid = 0; i_imem_ready = 0; i_imem_rdata_valid = 0; i_inst_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Transaction-level reference: one outstanding request, a flag saying
  // whether its response is still wanted, and at most one presented entry.
  task automatic randomPhase(input int cycles);
    logic [31:0] m_pc;
    bit          pend;
    bit          keep;
    entry_t      tag;
    entry_t      q[$];
    mreq_t       mq[$];
    bit          exp_req;
    bit          accept;
    resetDut();
    m_pc = 32'h0; pend = 0; keep = 0; tag = '{default: '0};
    for (int cyc = 0; cyc < cycles; cyc++) begin
      exp_req = !pend && (q.size() == 0);
      checkOutput("rnd_pc", o_pc, m_pc);
      checkOutput("rnd_imem_valid", o_imem_valid, exp_req);
      checkOutput("rnd_imem_addr", o_imem_addr, m_pc & 32'hFFFF_FFF8);
      checkOutput("rnd_inst_valid", o_inst_valid, q.size() != 0);
      if (q.size() != 0) begin
        checkOutput("rnd_inst_data", o_inst_data, q[0].data);
        checkOutput("rnd_inst_pc", o_inst_pc, q[0].pc);
        checkOutput("rnd_inst_lb", o_inst_lowerbound, q[0].pc[2]);
        checkOutput("rnd_inst_ub", o_inst_upperbound, q[0].ub);
        checkOutput("rnd_inst_gh", o_inst_global_history, q[0].gh);
      end
      i_redirect_valid = ($urandom % 10) == 0;
      i_redirect_pc    = $urandom;
      i_predicted_pc   = $urandom & 32'hFFFF_FFFC;
      i_pc_upperbound  = 1'($urandom);
      i_global_history = 4'($urandom);
      i_imem_ready     = ($urandom % 4) != 0;
      i_inst_ready     = ($urandom % 3) != 0;
      i_imem_rdata     = {$urandom, $urandom};
      i_imem_rdata_valid = 1'b0;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        i_imem_rdata_valid = 1'b1;
        i_imem_rdata       = mq[0].data;
        void'(mq.pop_front());
      end else if (!pend && mq.size() == 0 && ($urandom % 8) == 0) begin
        i_imem_rdata_valid = 1'b1;
      end
      accept = exp_req && i_imem_ready;
      if (q.size() != 0 && (i_redirect_valid || i_inst_ready)) void'(q.pop_front());
      if (pend && i_imem_rdata_valid) begin
        if (keep && !i_redirect_valid) begin
          tag.data = i_imem_rdata;
          q.push_back(tag);
        end
        pend = 0;
      end else if (pend && i_redirect_valid) begin
        keep = 0;
      end
      if (accept) begin
        mreq_t m;
        pend   = 1;
        keep   = !i_redirect_valid;
        tag.pc = m_pc;
        tag.ub = i_pc_upperbound;
        tag.gh = i_global_history;
        m.data = {$urandom, $urandom};
        m.due  = cyc + 1 + int'($urandom_range(0, 3));
        mq.push_back(m);
      end
      if (i_redirect_valid) m_pc = i_redirect_pc & 32'hFFFF_FFFC;
      else if (accept) m_pc = i_predicted_pc;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 32'h8, 1, 4'h5, 1, 0, 0, 0,   0, 32'h8, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 32'h8, 1, 4'h5, 0, 0, 0, 0,   0, 32'h8, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, D1, 0,         0, 32'h8, 1, 32'h0, 0, 1, D1);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 32'h8, 1, 32'h0, 0, 1, D1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 32'h8, 1, 32'h0, 0, 1, D1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 32'h8, 1, 32'h0, 0, 1, D1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,          1, 32'h8, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 32'h16, 0, 0, 0, 0, 0, 0, 0,     1, 32'h10, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 32'h18, 1, 4'h3, 1, 0, 0, 0,  0, 32'h18, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, D2, 0,         0, 32'h18, 1, 32'h14, 1, 1, D2);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,          1, 32'h18, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 32'h20, 0, 0, 1, 0, 0, 0,     0, 32'h20, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 32'h40, 0, 0, 0, 0, 0, 0, 0,     0, 32'h40, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 32'h40, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, D3, 0,         1, 32'h40, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          1, 32'h40, 0, 0, 0, 0, 0);

    #1;
    checkOutput("rst_inst_valid", o_inst_valid, 0);
    checkOutput("rst_inst_data", o_inst_data, 0);
    checkOutput("rst_pc", o_pc, 0);
    resetDut();
    checkOutput("rel_imem_valid", o_imem_valid, 1);
    checkOutput("rel_imem_addr", o_imem_addr, 0);
    checkOutput("rel_inst_valid", o_inst_valid, 0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_imem_valid", i), o_imem_valid, vecs[i].e_req);
      checkOutput($sformatf("vec%0d_imem_addr", i), o_imem_addr, vecs[i].e_addr);
      checkOutput($sformatf("vec%0d_inst_valid", i), o_inst_valid, vecs[i].e_iv);
      if (vecs[i].e_iv) begin
        checkOutput($sformatf("vec%0d_inst_pc", i), o_inst_pc, vecs[i].e_pc);
        checkOutput($sformatf("vec%0d_inst_lb", i), o_inst_lowerbound, vecs[i].e_lb);
        checkOutput($sformatf("vec%0d_inst_ub", i), o_inst_upperbound, vecs[i].e_ub);
        checkOutput($sformatf("vec%0d_inst_data", i), o_inst_data, vecs[i].e_data);
      end
    end

    // Redirect while an entry is held drops it immediately.
    applyStimulus(mk(0, 0, 32'h48, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, D1, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("hold_inst_valid", o_inst_valid, 1);
    checkOutput("hold_inst_pc", o_inst_pc, 32'h40);
    applyStimulus(mk(1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("hold_redir_inst_valid", o_inst_valid, 0);
    checkOutput("hold_redir_imem_valid", o_imem_valid, 1);
    checkOutput("hold_redir_pc", o_pc, 32'h80);

    // Redirect in the same cycle as an accepted request drains its response.
    applyStimulus(mk(1, 32'h101, 32'h88, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("acc_redir_imem_valid", o_imem_valid, 0);
    checkOutput("acc_redir_pc", o_pc, 32'h100);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, D2, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("drain_inst_valid", o_inst_valid, 0);
    checkOutput("drain_imem_valid", o_imem_valid, 1);

    // Redirect coinciding with the response drops the data.
    applyStimulus(mk(0, 0, 32'h108, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(mk(1, 32'h200, 0, 0, 0, 0, 1, D3, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("wait_redir_rd_inst_valid", o_inst_valid, 0);
    checkOutput("wait_redir_rd_imem_valid", o_imem_valid, 1);
    checkOutput("wait_redir_rd_pc", o_pc, 32'h200);

    // Reset while waiting: the late response must be ignored.
    applyStimulus(mk(0, 0, 32'h208, 1, 4'hA, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("pre_rst_imem_valid", o_imem_valid, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_imem_valid", o_imem_valid, 1);
    checkOutput("async_rst_pc", o_pc, 0);
    checkOutput("async_rst_inst_pc", o_inst_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, D1, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("post_rst_inst_valid", o_inst_valid, 0);
    checkOutput("post_rst_imem_valid", o_imem_valid, 1);
    checkOutput("post_rst_imem_addr", o_imem_addr, 0);

    randomPhase(3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter BW_ADDRESS, default 32, meaning byte address width.
REQ-002 SHALL have parameter BW_PROCESSOR_DATA, default 32, meaning instruction width.
REQ-003 SHALL have parameter BW_PROCESSOR_BLOCK, default 64, meaning fetch block width.
REQ-004 SHALL have parameter NUM_GLOBAL_HISTORY, default 4, meaning history tag width.
REQ-005 SHALL have parameter RESET_PC, default 0, meaning first fetch address.
REQ-006 SHALL derive NUM_ENTRY = BW_PROCESSOR_BLOCK/BW_PROCESSOR_DATA and BW_PC_MOD = clog2(NUM_ENTRY) + (NUM_ENTRY<=1).
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-009 SHALL have port i_redirect_valid, input, 1, mispredict redirect strobe.
REQ-010 SHALL have port i_redirect_pc, input, BW_ADDRESS, corrected next PC.
REQ-011 SHALL have port o_pc, output, BW_ADDRESS, current PC to predictor.
REQ-012 SHALL have ports i_predicted_pc (BW_ADDRESS), i_pc_upperbound (BW_PC_MOD) and i_global_history (NUM_GLOBAL_HISTORY), inputs, combinational predictor results for o_pc.
REQ-013 SHALL have ports o_imem_valid (1, output), i_imem_ready (1, input) and o_imem_addr (BW_ADDRESS, output), the block request handshake.
REQ-014 SHALL have ports i_imem_rdata_valid (1, input) and i_imem_rdata (BW_PROCESSOR_BLOCK, input), the block response.
REQ-015 SHALL have ports o_inst_valid (1, output) and i_inst_ready (1, input), the instruction-queue handshake.
REQ-016 SHALL have outputs o_inst_data (BLOCK), o_inst_pc (BW_ADDRESS), o_inst_lowerbound (BW_PC_MOD), o_inst_upperbound (BW_PC_MOD) and o_inst_global_history (NUM_GLOBAL_HISTORY).

Function
REQ-017 SHALL implement states S_REQ, S_WAIT, S_HOLD and S_DRAIN in a registered state machine.
REQ-018 SHALL drive o_pc from the PC register and o_imem_addr as o_pc with bits [BW_PC_MOD+1:0] cleared.
REQ-019 SHALL assert o_imem_valid only in S_REQ; a request is accepted when o_imem_valid && i_imem_ready.
REQ-020 On acceptance SHALL latch o_pc, i_pc_upperbound and i_global_history as tags, load PC <= i_predicted_pc and go to S_WAIT.
REQ-021 In S_WAIT, on i_imem_rdata_valid, SHALL register data and tags to the o_inst_* outputs and go to S_HOLD.
REQ-022 SHALL assert o_inst_valid exactly in S_HOLD, hold all o_inst_* stable until i_inst_ready, then go to S_REQ; latency from acceptance to o_inst_valid is response latency + 1 cycle.
REQ-023 SHALL drive o_inst_lowerbound from bits [BW_PC_MOD+1:2] of the tagged PC and o_inst_upperbound from the tagged upperbound (all-ones when no branch is taken).
REQ-024 On i_redirect_valid in any state SHALL load PC <= i_redirect_pc with bits [1:0] forced to 0; redirect overrides i_predicted_pc.
REQ-025 Redirect next state SHALL be: S_REQ with a same-cycle acceptance -> S_DRAIN; S_REQ otherwise -> S_REQ; S_WAIT without rdata -> S_DRAIN; S_WAIT with same-cycle rdata -> S_REQ, data dropped; S_HOLD -> S_REQ, entry dropped and o_inst_valid low next cycle; S_DRAIN -> S_DRAIN, or S_REQ if rdata arrives the same cycle.
REQ-026 In S_DRAIN SHALL discard the response without asserting o_inst_valid, then go to S_REQ.
REQ-027 SHALL ignore i_imem_rdata_valid in S_REQ and S_HOLD.
REQ-028 SHALL wrap PC arithmetic modulo 2^BW_ADDRESS.

Reset
REQ-029 On rst_n low SHALL immediately set state S_REQ, PC = RESET_PC, o_inst_valid = 0 and all o_inst_* data/tags to 0, discarding any outstanding request.
REQ-030 After reset release SHALL assert o_imem_valid in the first cycle.

Verification
REQ-031 Reset release -> o_imem_valid=1, o_imem_addr=0x0, o_inst_valid=0.
REQ-032 Request at 0x0 accepted, predictor 0x8 / upperbound 1, rdata 0x11112222_33334444 -> o_inst_valid with pc 0x0, lb 0, ub 1, data matched; next request addr 0x8.
REQ-033 Redirect to 0x16 in S_REQ -> next o_imem_addr 0x10; response delivers o_inst_pc 0x14, lowerbound 1.
REQ-034 Redirect to 0x40 in S_WAIT, stale rdata two cycles later -> no o_inst_valid; next request addr 0x40.
REQ-035 i_inst_ready low for 3 cycles in S_HOLD -> o_inst_* stable, o_imem_valid=0; request issued the cycle after ready.
REQ-036 rst_n low during S_WAIT, response arrives after release -> response ignored, o_inst_valid stays 0, request at RESET_PC.
